// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side hazard interface: instruction operand/destination info in,
// interlock status and occupancy out.
interface pipe_hazard_scoreboard_if #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned STALL_CNT_W = 32
);
   logic                         dec_valid;
   logic                         dec_rs1_used;
   logic [REG_ADDR_W-1:0]        dec_rs1;
   logic                         dec_rs2_used;
   logic [REG_ADDR_W-1:0]        dec_rs2;
   logic                         dec_rd_we;
   logic [REG_ADDR_W-1:0]        dec_rd;
   logic                         flush;
   logic                         stall;
   logic                         issue;
   logic [(2**REG_ADDR_W)-1:0]   pending;
   logic [STALL_CNT_W-1:0]       stall_cnt;

   modport master (
      output dec_valid, dec_rs1_used, dec_rs1, dec_rs2_used, dec_rs2,
             dec_rd_we, dec_rd, flush,
      input  stall, issue, pending, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_rs1_used, dec_rs1, dec_rs2_used, dec_rs2,
             dec_rd_we, dec_rd, flush,
      output stall, issue, pending, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// RAW-hazard scoreboard: tracks in-flight destination registers from issue to
// writeback and interlocks decode on read-after-write conflicts.
module pipe_hazard_scoreboard #(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned PIPE_DEPTH  = 4,
   parameter int unsigned WB_BYPASS   = 1,
   parameter int unsigned FLUSH_KILL  = 0,
   parameter int unsigned STALL_CNT_W = 32
) (
   input logic                clk,
   input logic                rstn,
   pipe_hazard_scoreboard_if.slave hz
);

   localparam int unsigned NREG      = 2**REG_ADDR_W;
   localparam int unsigned HAZ_DEPTH = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;
   localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

   logic [PIPE_DEPTH-1:0]  v_q, v_d;
   logic [REG_ADDR_W-1:0]  rd_q [PIPE_DEPTH];
   logic [REG_ADDR_W-1:0]  rd_d [PIPE_DEPTH];
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic hit1, hit2, hazard, stall, issue;
   logic [NREG-1:0] pending;

   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int unsigned k = 0; k < HAZ_DEPTH; k++) begin
         if (v_q[k] && (rd_q[k] == hz.dec_rs1)) hit1 = 1'b1;
         if (v_q[k] && (rd_q[k] == hz.dec_rs2)) hit2 = 1'b1;
      end
      if (hz.dec_rs1 == '0) hit1 = 1'b0;
      if (hz.dec_rs2 == '0) hit2 = 1'b0;

      hazard = hz.dec_valid & ((hz.dec_rs1_used & hit1) | (hz.dec_rs2_used & hit2));
      stall  = hazard & ~hz.flush;
      issue  = hz.dec_valid & ~hazard & ~hz.flush;

      pending = '0;
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
         if (v_q[k]) pending[rd_q[k]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

   // On flush the FLUSH_KILL youngest in-flight instructions are dropped as they
   // shift; slot 0 itself is already a bubble because nothing issues.
   always_comb begin
      v_d[0]  = issue & hz.dec_rd_we & (hz.dec_rd != '0);
      rd_d[0] = issue ? hz.dec_rd : '0;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
         v_d[k]  = v_q[k-1];
         rd_d[k] = rd_q[k-1];
         if (hz.flush && (k <= FLUSH_KILL)) v_d[k] = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_q         <= '0;
         stall_cnt_q <= '0;
         for (int unsigned k = 0; k < PIPE_DEPTH; k++) rd_q[k] <= '0;
      end else begin
         v_q         <= v_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall     = stall;
   assign hz.issue     = issue;
   assign hz.pending   = pending;
   assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench: instance A uses default parameters, instance B uses
// WB_BYPASS=0, FLUSH_KILL=1 and a 4-bit stall counter.
module tb_pipe_hazard_scoreboard;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(32)) ia ();
   pipe_hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(4))  ib ();

   pipe_hazard_scoreboard #(
      .REG_ADDR_W(5), .PIPE_DEPTH(4), .WB_BYPASS(1), .FLUSH_KILL(0), .STALL_CNT_W(32)
   ) u_a (
      .clk (clk),
      .rstn(rstn),
      .hz  (ia.slave)
   );

   pipe_hazard_scoreboard #(
      .REG_ADDR_W(5), .PIPE_DEPTH(4), .WB_BYPASS(0), .FLUSH_KILL(1), .STALL_CNT_W(4)
   ) u_b (
      .clk (clk),
      .rstn(rstn),
      .hz  (ib.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic v, input logic r1u, input logic [4:0] r1,
                        input logic r2u, input logic [4:0] r2,
                        input logic we, input logic [4:0] rd, input logic fl);
      ia.dec_valid = v;  ia.dec_rs1_used = r1u; ia.dec_rs1 = r1;
      ia.dec_rs2_used = r2u; ia.dec_rs2 = r2;
      ia.dec_rd_we = we; ia.dec_rd = rd; ia.flush = fl;
      #1;
   endtask

   task automatic drv_b(input logic v, input logic r1u, input logic [4:0] r1,
                        input logic r2u, input logic [4:0] r2,
                        input logic we, input logic [4:0] rd, input logic fl);
      ib.dec_valid = v;  ib.dec_rs1_used = r1u; ib.dec_rs1 = r1;
      ib.dec_rs2_used = r2u; ib.dec_rs2 = r2;
      ib.dec_rd_we = we; ib.dec_rd = rd; ib.flush = fl;
      #1;
   endtask

   initial begin
      // Reset held two cycles with a valid rs1=5 reader in decode
      drv_a(1, 1, 5, 0, 0, 0, 0, 0);
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);
      rstn = 1'b0;
      tick();
      tick();
      chk("a_rst_stall",   32'(ia.stall),     32'd0);
      chk("a_rst_pending", ia.pending,        32'd0);
      chk("a_rst_cnt",     ia.stall_cnt,      32'd0);
      chk("b_rst_pending", ib.pending,        32'd0);
      chk("b_rst_cnt",     32'(ib.stall_cnt), 32'd0);
      rstn = 1'b1;
      #1;
      chk("a_rel_issue",   32'(ia.issue),     32'd1);
      tick();

      // Back-to-back RAW on A: 3 stall cycles with write-through regfile
      drv_a(1, 0, 0, 0, 0, 1, 5, 0);
      chk("a_raw_prod_issue", 32'(ia.issue), 32'd1);
      tick();
      drv_a(1, 1, 5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         chk("a_raw_stall",   32'(ia.stall), 32'd1);
         chk("a_raw_noissue", 32'(ia.issue), 32'd0);
         chk("a_raw_pend5",   ia.pending,    32'h20);
         tick();
      end
      chk("a_raw_release", 32'(ia.stall), 32'd0);
      chk("a_raw_issue",   32'(ia.issue), 32'd1);
      chk("a_raw_cnt",     ia.stall_cnt,  32'd3);
      chk("a_raw_pend_wb", ia.pending,    32'h20);
      tick();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      chk("a_raw_drained", ia.pending,    32'd0);
      chk("a_raw_cnt2",    ia.stall_cnt,  32'd3);

      // x0 is never recorded or matched; independent registers pass
      drv_a(1, 0, 0, 0, 0, 1, 0, 0);
      chk("a_x0_issue", 32'(ia.issue), 32'd1);
      tick();
      drv_a(1, 1, 0, 1, 0, 0, 0, 0);
      chk("a_x0_stall", 32'(ia.stall), 32'd0);
      chk("a_x0_issue2", 32'(ia.issue), 32'd1);
      chk("a_x0_pend",  ia.pending,    32'd0);
      tick();
      drv_a(1, 0, 0, 0, 0, 1, 3, 0);
      tick();
      drv_a(1, 1, 4, 1, 6, 0, 0, 0);
      chk("a_indep_stall", 32'(ia.stall), 32'd0);
      chk("a_indep_issue", 32'(ia.issue), 32'd1);
      chk("a_indep_pend",  ia.pending,    32'h08);
      tick();

      // Flush beats hazard; FLUSH_KILL=0 keeps rd=7 in flight
      drv_a(1, 0, 0, 0, 0, 1, 7, 0);
      tick();
      drv_a(1, 0, 0, 1, 7, 0, 0, 1);
      chk("a_fl_stall", 32'(ia.stall), 32'd0);
      chk("a_fl_issue", 32'(ia.issue), 32'd0);
      chk("a_fl_pend",  ia.pending,    32'h88);
      tick();
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      chk("a_fl_pend_after", ia.pending, 32'h88);
      for (int i = 0; i < 4; i++) tick();
      chk("a_fl_drained", ia.pending, 32'd0);

      // Reset asserted in the middle of a stall
      drv_a(1, 0, 0, 0, 0, 1, 5, 0);
      tick();
      drv_a(1, 1, 5, 0, 0, 0, 0, 0);
      chk("a_mid_stall0", 32'(ia.stall), 32'd1);
      tick();
      chk("a_mid_stall1", 32'(ia.stall), 32'd1);
      chk("a_mid_cnt",    ia.stall_cnt,  32'd4);
      rstn = 1'b0;
      tick();
      chk("a_mid_rst_cnt",   ia.stall_cnt,  32'd0);
      chk("a_mid_rst_pend",  ia.pending,    32'd0);
      chk("a_mid_rst_stall", 32'(ia.stall), 32'd0);
      rstn = 1'b1;
      drv_a(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // B: RAW without write-through costs 4 stall cycles
      drv_b(1, 0, 0, 0, 0, 1, 5, 0);
      chk("b_raw_prod_issue", 32'(ib.issue), 32'd1);
      tick();
      drv_b(1, 1, 5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         chk("b_raw_stall", 32'(ib.stall), 32'd1);
         tick();
      end
      chk("b_raw_issue", 32'(ib.issue),     32'd1);
      chk("b_raw_cnt",   32'(ib.stall_cnt), 32'd4);
      tick();
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // B: FLUSH_KILL=1 drops the youngest in-flight rd=7
      drv_b(1, 0, 0, 0, 0, 1, 7, 0);
      tick();
      drv_b(1, 0, 0, 1, 7, 0, 0, 1);
      chk("b_fl_stall", 32'(ib.stall), 32'd0);
      chk("b_fl_issue", 32'(ib.issue), 32'd0);
      chk("b_fl_pend",  ib.pending,    32'h80);
      tick();
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);
      chk("b_fl_killed", ib.pending, 32'd0);

      // B: self-dependent instruction repeats issue + 4 stalls; counter saturates
      drv_b(1, 1, 5, 0, 0, 1, 5, 0);
      for (int i = 0; i < 10; i++) tick();
      chk("b_sat_mid", 32'(ib.stall_cnt), 32'd12);
      for (int i = 0; i < 15; i++) tick();
      chk("b_sat_cnt",   32'(ib.stall_cnt), 32'd15);
      chk("b_sat_issue", 32'(ib.issue),     32'd1);
      tick();
      chk("b_sat_stall", 32'(ib.stall),     32'd1);
      tick();
      chk("b_sat_hold",  32'(ib.stall_cnt), 32'd15);
      drv_b(0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
